// File: rtl/tab_lkup_pkg.sv
// +------------------------------------------------------------------+
// | tab_lkup_pkg : shared FSM encoding and info-word field offsets   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package tab_lkup_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INFO = 2'd1,
        PD   = 2'd2,
        RSLT = 2'd3
    } state_t;

    localparam int LKUP_EN_BIT = 0;
    localparam int PCNT_LSB    = 1;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tab_lkup_tmo.sv
// +------------------------------------------------------------------+
// | tab_lkup_tmo : stall watchdog, counts source-empty cycles        |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tab_lkup_tmo #(
    parameter int TMO_WID = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inc,
    input  logic               clr,
    input  logic [TMO_WID-1:0] thr,
    output logic               expire
);

    logic [TMO_WID-1:0] r_cnt;
    logic [TMO_WID-1:0] w_cnt_inc;

    assign w_cnt_inc = r_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && !(&r_cnt)) begin
            r_cnt <= w_cnt_inc;
        end
    end

    // Fires on the stall cycle that brings the count up to the threshold.
    assign expire = inc && (thr != '0) && (w_cnt_inc == thr);

endmodule

`default_nettype wire

// File: rtl/tab_lkup_align.sv
// +------------------------------------------------------------------+
// | tab_lkup_align : merges info / PD / result FIFOs into streams    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tab_lkup_align
    import tab_lkup_pkg::*;
#(
    parameter int  PDWID    = 128,
    parameter int  TAB_DWID = 128,
    parameter int  PD_MAX   = 4,
    parameter int  RSLT_SZ  = 2,
    parameter int  TMO_WID  = 16,
    parameter int  DBG_WID  = 32,
    localparam int PCW      = $clog2(PD_MAX),
    localparam int INFO_WID = PCW + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_info_nempty,
    output logic                in_info_ren,
    input  logic [INFO_WID-1:0] in_info_rdata,
    input  logic                in_pd_nempty,
    output logic                in_pd_ren,
    input  logic [PDWID-1:0]    in_pd_rdata,
    input  logic                in_rslt_nempty,
    output logic                in_rslt_ren,
    input  logic [TAB_DWID-1:0] in_rslt_rdata,
    output logic                out_info_vld,
    input  logic                out_info_rdy,
    output logic [INFO_WID-1:0] out_info_dat,
    output logic                out_pd_vld,
    input  logic                out_pd_rdy,
    output logic [PDWID-1:0]    out_pd_dat,
    output logic                out_pd_last,
    output logic                out_rslt_vld,
    input  logic                out_rslt_rdy,
    output logic [TAB_DWID-1:0] out_rslt_dat,
    output logic                out_rslt_last,
    input  logic [TMO_WID-1:0]  cfg_tmo,
    output logic                err_tmo,
    output logic [15:0]         cnt_tmo,
    output logic [DBG_WID-1:0]  dbg_sig
);

    localparam int RSW     = (RSLT_SZ > 1) ? $clog2(RSLT_SZ) : 1;
    localparam int IDXW    = max2(PCW, RSW);
    localparam int DBG_RAW = 2 + IDXW + 8;

    state_t              r_state;
    state_t              w_next;
    logic                r_run;
    logic [INFO_WID-1:0] r_info;
    logic [IDXW-1:0]     r_idx;
    logic                r_err;
    logic [15:0]         r_cnt_tmo;

    logic                w_lkup;
    logic [PCW-1:0]      w_pcnt;
    logic                w_pd_last;
    logic                w_rs_last;
    logic                w_pd_xfer;
    logic                w_rs_xfer;
    logic                w_stall;
    logic                w_clr;
    logic                w_expire;
    logic [DBG_RAW-1:0]  w_dbg_raw;

    assign w_lkup    = r_info[LKUP_EN_BIT];
    assign w_pcnt    = r_info[PCNT_LSB +: PCW];
    assign w_pd_last = (r_idx == IDXW'(w_pcnt));
    assign w_rs_last = (r_idx == IDXW'(RSLT_SZ - 1));
    assign w_pd_xfer = in_pd_ren;
    assign w_rs_xfer = in_rslt_ren;

    // r_run holds off the IDLE info pop until the first edge after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_run   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_run   <= 1'b1;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (in_info_ren) w_next = INFO;
            INFO: if (out_info_rdy) w_next = PD;
            PD: begin
                if (w_pd_xfer && w_pd_last) w_next = w_lkup ? RSLT : IDLE;
                else if (w_expire)          w_next = IDLE;
            end
            RSLT: begin
                if (w_rs_xfer && w_rs_last) w_next = IDLE;
                else if (w_expire)          w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        in_info_ren   = 1'b0;
        in_pd_ren     = 1'b0;
        in_rslt_ren   = 1'b0;
        out_info_vld  = 1'b0;
        out_info_dat  = '0;
        out_pd_vld    = 1'b0;
        out_pd_dat    = '0;
        out_pd_last   = 1'b0;
        out_rslt_vld  = 1'b0;
        out_rslt_dat  = '0;
        out_rslt_last = 1'b0;
        case (r_state)
            IDLE: in_info_ren = r_run && in_info_nempty;
            INFO: begin
                out_info_vld = 1'b1;
                out_info_dat = r_info;
            end
            PD: begin
                out_pd_vld  = in_pd_nempty;
                out_pd_dat  = in_pd_rdata;
                out_pd_last = w_pd_last;
                in_pd_ren   = in_pd_nempty && out_pd_rdy;
            end
            RSLT: begin
                out_rslt_vld  = in_rslt_nempty;
                out_rslt_dat  = in_rslt_rdata;
                out_rslt_last = w_rs_last;
                in_rslt_ren   = in_rslt_nempty && out_rslt_rdy;
            end
            default: ;
        endcase
    end

    // One index serves both PD and result cells; it restarts on every state change.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_info    <= '0;
            r_idx     <= '0;
            r_err     <= 1'b0;
            r_cnt_tmo <= '0;
        end else begin
            if (in_info_ren) r_info <= in_info_rdata;
            if (w_next != r_state)           r_idx <= '0;
            else if (w_pd_xfer || w_rs_xfer) r_idx <= r_idx + 1'b1;
            r_err <= w_expire;
            if (w_expire && (r_cnt_tmo != 16'hFFFF)) r_cnt_tmo <= r_cnt_tmo + 1'b1;
        end
    end

    assign w_stall = ((r_state == PD)   && !in_pd_nempty) ||
                     ((r_state == RSLT) && !in_rslt_nempty);
    assign w_clr   = w_pd_xfer || w_rs_xfer || (w_next != r_state);

    tab_lkup_tmo #(
        .TMO_WID (TMO_WID)
    ) u_tmo (
        .clk    (clk),
        .rst    (rst),
        .inc    (w_stall),
        .clr    (w_clr),
        .thr    (cfg_tmo),
        .expire (w_expire)
    );

    assign err_tmo   = r_err;
    assign cnt_tmo   = r_cnt_tmo;
    assign w_dbg_raw = {r_state, r_idx, r_cnt_tmo[7:0]};

    generate
        if (DBG_WID > DBG_RAW) begin : g_dbg_pad
            assign dbg_sig = {{(DBG_WID - DBG_RAW){1'b0}}, w_dbg_raw};
        end else if (DBG_WID == DBG_RAW) begin : g_dbg_exact
            assign dbg_sig = w_dbg_raw;
        end else begin : g_dbg_trunc
            assign dbg_sig = w_dbg_raw[DBG_WID-1:0];
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_tab_lkup_align.sv
// +------------------------------------------------------------------+
// | tb_tab_lkup_align : FIFO/sink model bench for tab_lkup_align     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_tab_lkup_align;

    localparam int PDWID    = 128;
    localparam int TAB_DWID = 128;
    localparam int PD_MAX   = 4;
    localparam int RSLT_SZ  = 2;
    localparam int TMO_WID  = 16;
    localparam int DBG_WID  = 32;
    localparam int INFO_WID = 3;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                in_info_nempty, in_info_ren;
    logic [INFO_WID-1:0] in_info_rdata;
    logic                in_pd_nempty, in_pd_ren;
    logic [PDWID-1:0]    in_pd_rdata;
    logic                in_rslt_nempty, in_rslt_ren;
    logic [TAB_DWID-1:0] in_rslt_rdata;
    logic                out_info_vld, out_info_rdy;
    logic [INFO_WID-1:0] out_info_dat;
    logic                out_pd_vld, out_pd_rdy, out_pd_last;
    logic [PDWID-1:0]    out_pd_dat;
    logic                out_rslt_vld, out_rslt_rdy, out_rslt_last;
    logic [TAB_DWID-1:0] out_rslt_dat;
    logic [TMO_WID-1:0]  cfg_tmo;
    logic                err_tmo;
    logic [15:0]         cnt_tmo;
    logic [DBG_WID-1:0]  dbg_sig;

    always #5 clk = ~clk;

    tab_lkup_align #(
        .PDWID (PDWID), .TAB_DWID (TAB_DWID), .PD_MAX (PD_MAX),
        .RSLT_SZ (RSLT_SZ), .TMO_WID (TMO_WID), .DBG_WID (DBG_WID)
    ) dut (
        .clk (clk), .rst (rst),
        .in_info_nempty (in_info_nempty), .in_info_ren (in_info_ren), .in_info_rdata (in_info_rdata),
        .in_pd_nempty (in_pd_nempty), .in_pd_ren (in_pd_ren), .in_pd_rdata (in_pd_rdata),
        .in_rslt_nempty (in_rslt_nempty), .in_rslt_ren (in_rslt_ren), .in_rslt_rdata (in_rslt_rdata),
        .out_info_vld (out_info_vld), .out_info_rdy (out_info_rdy), .out_info_dat (out_info_dat),
        .out_pd_vld (out_pd_vld), .out_pd_rdy (out_pd_rdy), .out_pd_dat (out_pd_dat),
        .out_pd_last (out_pd_last),
        .out_rslt_vld (out_rslt_vld), .out_rslt_rdy (out_rslt_rdy), .out_rslt_dat (out_rslt_dat),
        .out_rslt_last (out_rslt_last),
        .cfg_tmo (cfg_tmo), .err_tmo (err_tmo), .cnt_tmo (cnt_tmo), .dbg_sig (dbg_sig)
    );

    // FIFO contents, staged sources, expected output streams ({last, dat}).
    logic [INFO_WID-1:0] info_q[$], src_info[$], exp_info[$];
    logic [PDWID-1:0]    pd_q[$], src_pd[$];
    logic [TAB_DWID-1:0] rs_q[$], src_rs[$], hold_rs[$];
    logic [PDWID:0]      exp_pd[$];
    logic [TAB_DWID:0]   exp_rs[$];
    int                  cyc_info[$], cyc_pd[$], cyc_rs[$];
    int                  cyc = 0;
    int                  n_pd_pop = 0;
    int                  feed_pct = 100;
    bit                  rand_rdy = 1'b0;
    int                  n_chk = 0;
    int                  n_err = 0;

    task automatic chk(input string tag, input logic [159:0] act, input logic [159:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic drive_fifos();
        in_info_nempty = (info_q.size() != 0);
        in_info_rdata  = (info_q.size() != 0) ? info_q[0] : '0;
        in_pd_nempty   = (pd_q.size() != 0);
        in_pd_rdata    = (pd_q.size() != 0) ? pd_q[0] : '0;
        in_rslt_nempty = (rs_q.size() != 0);
        in_rslt_rdata  = (rs_q.size() != 0) ? rs_q[0] : '0;
    endtask

    task automatic feed();
        int k;
        k = (feed_pct >= 100) ? 1000 : (($urandom_range(99) < feed_pct) ? 1 : 0);
        while (k > 0 && src_info.size() > 0) begin info_q.push_back(src_info.pop_front()); k--; end
        k = (feed_pct >= 100) ? 1000 : (($urandom_range(99) < feed_pct) ? 1 : 0);
        while (k > 0 && src_pd.size() > 0) begin pd_q.push_back(src_pd.pop_front()); k--; end
        k = (feed_pct >= 100) ? 1000 : (($urandom_range(99) < feed_pct) ? 1 : 0);
        while (k > 0 && src_rs.size() > 0) begin rs_q.push_back(src_rs.pop_front()); k--; end
    endtask

    task automatic clear_all();
        info_q.delete(); src_info.delete(); exp_info.delete();
        pd_q.delete(); src_pd.delete(); exp_pd.delete();
        rs_q.delete(); src_rs.delete(); hold_rs.delete(); exp_rs.delete();
        cyc_info.delete(); cyc_pd.delete(); cyc_rs.delete();
        n_pd_pop = 0;
    endtask

    // A descriptor is cnt+1 PD cells, plus RSLT_SZ result cells when lkup is set.
    task automatic push_desc(input int cnt, input bit lkup, input bit with_rs);
        logic [INFO_WID-1:0] inf;
        logic [127:0]        d;
        inf = {2'(cnt), lkup};
        src_info.push_back(inf);
        exp_info.push_back(inf);
        for (int i = 0; i <= cnt; i++) begin
            d = rnd128();
            src_pd.push_back(d);
            exp_pd.push_back({(i == cnt), d});
        end
        if (lkup) begin
            for (int i = 0; i < RSLT_SZ; i++) begin
                d = rnd128();
                if (with_rs) src_rs.push_back(d);
                else         hold_rs.push_back(d);
                exp_rs.push_back({(i == RSLT_SZ - 1), d});
            end
        end
    endtask

    task automatic step();
        logic p_info, p_pd, p_rs;
        @(negedge clk);
        cyc++;
        if (out_info_vld && out_info_rdy) begin
            cyc_info.push_back(cyc);
            if (exp_info.size() == 0) chk("info_extra", 1, 0);
            else                      chk("info_dat", out_info_dat, exp_info.pop_front());
        end
        if (out_pd_vld && exp_pd.size() == 0) begin
            if (out_pd_rdy) chk("pd_extra", 1, 0);
        end else if (out_pd_vld) begin
            if (out_pd_rdy) begin
                cyc_pd.push_back(cyc);
                chk("pd_beat", {out_pd_last, out_pd_dat}, exp_pd.pop_front());
            end else begin
                chk("pd_hold", {out_pd_last, out_pd_dat}, exp_pd[0]);
            end
        end
        if (out_rslt_vld && exp_rs.size() == 0) begin
            if (out_rslt_rdy) chk("rs_extra", 1, 0);
        end else if (out_rslt_vld) begin
            if (out_rslt_rdy) begin
                cyc_rs.push_back(cyc);
                chk("rs_beat", {out_rslt_last, out_rslt_dat}, exp_rs.pop_front());
            end else begin
                chk("rs_hold", {out_rslt_last, out_rslt_dat}, exp_rs[0]);
            end
        end
        p_info = in_info_ren;
        p_pd   = in_pd_ren;
        p_rs   = in_rslt_ren;
        if (p_pd) n_pd_pop++;
        @(posedge clk);
        #1;
        if (p_info && info_q.size() != 0) void'(info_q.pop_front());
        if (p_pd && pd_q.size() != 0)     void'(pd_q.pop_front());
        if (p_rs && rs_q.size() != 0)     void'(rs_q.pop_front());
        feed();
        if (rand_rdy) begin
            out_info_rdy = ($urandom_range(3) != 0);
            out_pd_rdy   = ($urandom_range(3) != 0);
            out_rslt_rdy = ($urandom_range(3) != 0);
        end
        drive_fifos();
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while (!(exp_info.size() == 0 && exp_pd.size() == 0 && exp_rs.size() == 0) && n < budget) begin
            step();
            n++;
        end
        chk(tag, (n < budget), 1);
    endtask

    task automatic wait_pd_beats(input string tag, input int beats);
        int n;
        n = 0;
        while (cyc_pd.size() < beats && n < 50) begin
            step();
            n++;
        end
        chk(tag, (cyc_pd.size() == beats), 1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_all();
        drive_fifos();
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout act=%0d exp=done", cyc);
        $fatal(1);
    end

    initial begin
        out_info_rdy = 1'b1;
        out_pd_rdy   = 1'b1;
        out_rslt_rdy = 1'b1;
        cfg_tmo      = '0;
        clear_all();

        // Reset state, with a full descriptor already waiting in the FIFOs.
        push_desc(3, 1'b1, 1'b1);
        feed();
        drive_fifos();
        #2;
        chk("rst_info_ren", in_info_ren, 0);
        chk("rst_info_vld", out_info_vld, 0);
        chk("rst_pd_vld", out_pd_vld, 0);
        chk("rst_rs_vld", out_rslt_vld, 0);
        chk("rst_err", err_tmo, 0);
        chk("rst_cnt_tmo", cnt_tmo, 0);
        chk("rst_dbg", dbg_sig, 0);
        @(posedge clk);
        #3 rst = 1'b1;
        #1 chk("rel_info_ren", in_info_ren, 0);
        @(posedge clk);
        #1;

        // Full lookup descriptor, everything ready: back-to-back beats.
        drain("full_drain", 40);
        chk("full_ninfo", cyc_info.size(), 1);
        chk("full_npd", cyc_pd.size(), 4);
        chk("full_nrs", cyc_rs.size(), 2);
        if (cyc_info.size() == 1 && cyc_pd.size() == 4 && cyc_rs.size() == 2) begin
            for (int i = 0; i < 4; i++) chk("full_pd_cyc", cyc_pd[i], cyc_info[0] + 1 + i);
            for (int i = 0; i < 2; i++) chk("full_rs_cyc", cyc_rs[i], cyc_info[0] + 5 + i);
        end

        // Single-cell descriptor without lookup; a stray result must stay queued.
        clear_all();
        push_desc(0, 1'b0, 1'b0);
        rs_q.push_back(rnd128());
        drive_fifos();
        drain("nolk_drain", 40);
        repeat (3) step();
        chk("nolk_npd", cyc_pd.size(), 1);
        chk("nolk_rs_beats", cyc_rs.size(), 0);
        chk("nolk_rs_kept", rs_q.size(), 1);

        // Sink backpressure on PD: ready alternates every cycle.
        do_reset();
        push_desc(3, 1'b0, 1'b0);
        feed();
        drive_fifos();
        for (int i = 0; i < 40 && (exp_info.size() != 0 || exp_pd.size() != 0); i++) begin
            out_pd_rdy = (i % 2 == 0);
            step();
        end
        out_pd_rdy = 1'b1;
        chk("bp_pops", n_pd_pop, 4);
        chk("bp_beats", cyc_pd.size(), 4);
        chk("bp_left", exp_pd.size(), 0);

        // Result FIFO stays empty: watchdog expires 5 cycles into RSLT.
        do_reset();
        cfg_tmo = 16'd5;
        push_desc(0, 1'b1, 1'b0);
        feed();
        drive_fifos();
        wait_pd_beats("tmo_pd", 1);
        for (int k = 1; k <= 7; k++) begin
            step();
            chk($sformatf("tmo_err_k%0d", k), err_tmo, (k == 5));
        end
        chk("tmo_cnt", cnt_tmo, 1);
        chk("tmo_dbg_cnt", dbg_sig[7:0], 8'd1);
        rs_q.push_back(rnd128());
        drive_fifos();
        #1;
        chk("tmo_idle_vld", out_rslt_vld, 0);
        chk("tmo_idle_ren", in_rslt_ren, 0);
        rs_q.delete();
        exp_rs.delete();
        hold_rs.delete();
        drive_fifos();

        // Asynchronous reset in the middle of a PD burst, then a clean descriptor.
        cfg_tmo = '0;
        clear_all();
        push_desc(3, 1'b0, 1'b0);
        feed();
        drive_fifos();
        wait_pd_beats("mid_pd2", 2);
        #2 rst = 1'b0;
        #1;
        chk("mid_pd_vld", out_pd_vld, 0);
        chk("mid_pd_ren", in_pd_ren, 0);
        chk("mid_pd_last", out_pd_last, 0);
        chk("mid_cnt_tmo", cnt_tmo, 0);
        chk("mid_dbg", dbg_sig, 0);
        clear_all();
        push_desc(1, 1'b1, 1'b1);
        feed();
        drive_fifos();
        #1 chk("mid_hold_ren", in_info_ren, 0);
        @(posedge clk);
        #3 rst = 1'b1;
        #1 chk("mid_rel_ren", in_info_ren, 0);
        @(posedge clk);
        #1;
        drain("mid_drain", 40);
        chk("mid_npd", cyc_pd.size(), 2);
        chk("mid_nrs", cyc_rs.size(), 2);

        // Result cell lands on the very cycle the watchdog would expire.
        do_reset();
        cfg_tmo = 16'd5;
        push_desc(0, 1'b1, 1'b0);
        feed();
        drive_fifos();
        wait_pd_beats("race_pd", 1);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("race_err_pre", err_tmo, 0);
        end
        while (hold_rs.size() != 0) rs_q.push_back(hold_rs.pop_front());
        drive_fifos();
        for (int k = 5; k <= 8; k++) begin
            step();
            chk("race_err_post", err_tmo, 0);
        end
        chk("race_left", exp_rs.size(), 0);
        chk("race_cnt", cnt_tmo, 0);
        if (cyc_rs.size() != 0 && cyc_pd.size() != 0) chk("race_rs_cyc", cyc_rs[0], cyc_pd[0] + 5);
        else chk("race_rs_beat", cyc_rs.size(), 2);

        // Random descriptors, random FIFO fill and random sink backpressure.
        do_reset();
        cfg_tmo  = '0;
        feed_pct = 60;
        rand_rdy = 1'b1;
        for (int i = 0; i < 40; i++) push_desc($urandom_range(3), 1'($urandom_range(1)), 1'b1);
        drain("rand_drain", 4000);
        chk("rand_info_left", info_q.size(), 0);
        chk("rand_pd_left", pd_q.size(), 0);
        chk("rand_rs_left", rs_q.size(), 0);
        chk("rand_cnt_tmo", cnt_tmo, 0);
        rand_rdy = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

`default_nettype wire
